// File: rtl/seq_booth_multiplier_if.sv
// Operand/result handshake bundle for seq_booth_multiplier.
// The master side supplies operands and takes results; the slave side is the multiplier.
interface seq_booth_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, is_signed, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, is_signed, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-4 Booth multiplier, one partial product per cycle, valid/ready on both sides.
// Optional SEQ_MUL_EARLY_TERM_EN: a zero operand skips the iterations and completes immediately.
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_booth_multiplier_if.slave bus
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [AW-1:0]        r_mcand;
  logic [AW-1:0]        r_acc;
  logic [AW-1:0]        w_pp;
  logic [AW-1:0]        w_accNext;
  logic [EW-1:0]        r_mplier;
  logic                 r_mplierPrev;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;
  logic                 w_accept;
  logic                 w_zeroOp;
  logic                 w_aSign;
  logic                 w_bSign;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_aSign  = bus.is_signed && bus.a[WIDTH-1];
  assign w_bSign  = bus.is_signed && bus.b[WIDTH-1];

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign w_zeroOp = (bus.a == '0) || (bus.b == '0);
`else
  assign w_zeroOp = 1'b0;
`endif

  // The multiplicand is pre-shifted by 2 each cycle, so the digit always scales the current weight.
  always_comb begin
    w_pp = '0;
    case ({r_mplier[1:0], r_mplierPrev})
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = r_mcand << 1;
      3'b100:         w_pp = -(r_mcand << 1);
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_accNext = r_acc + w_pp;

  always_comb begin
    w_stateNext   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_stateNext = w_zeroOp ? DONE : BUSY;
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (r_count == CW'(1)) w_stateNext = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Operands are captured only on accept, so junk on a/b at other times never reaches state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_mplierPrev <= 1'b0;
      r_acc        <= '0;
      r_count      <= '0;
      r_product    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand      <= {{(AW-WIDTH){w_aSign}}, bus.a};
            r_mplier     <= {{2{w_bSign}}, bus.b};
            r_mplierPrev <= 1'b0;
            r_acc        <= '0;
            r_count      <= CW'(ITER);
            if (w_zeroOp) r_product <= '0;
          end
        end
        BUSY: begin
          r_acc        <= w_accNext;
          r_mcand      <= r_mcand << 2;
          r_mplier     <= r_mplier >> 2;
          r_mplierPrev <= r_mplier[1];
          r_count      <= r_count - CW'(1);
          if (r_count == CW'(1)) r_product <= w_accNext[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.product = r_product;
endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Parametrised sequential radix-4 Booth multiplier. Successor to the combinational 32x32 signed multiplier. Adds a configurable operand width and a per-operation signed/unsigned mode. Uses a valid/ready handshake on input and output, so it sits in the ALU datapath as a multi-cycle functional unit. Trades latency for area: one partial product per cycle, no full array.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4; product is 2*WIDTH bits.
- ITER (localparam), WIDTH/2+1, Booth iterations per operation; operands extended to WIDTH+2 bits.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, unit can accept operands.
- is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled at accept.
- a, input, WIDTH, multiplicand.
- b, input, WIDTH, multiplier.
- out_valid, output, 1, product valid.
- out_ready, input, 1, consumer takes product.
- product, output, 2*WIDTH, result; signed or unsigned per the latched is_signed.
- busy, output, 1, high in BUSY or DONE.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; product=0; iteration counter=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a and b, extended to WIDTH+2 bits: sign-extend if is_signed, else zero-extend.
  - Latch is_signed, clear the accumulator, load counter=ITER, go to BUSY.
- FSM BUSY:
  - in_ready=0.
  - Each cycle, recode multiplier bits {b[2i+1], b[2i], b[2i-1]} (b[-1]=0) to a digit in {-2,-1,0,+1,+2}.
  - Add digit*a, as a 2*WIDTH+2-bit two's-complement value, shifted by 2i, into the accumulator. Decrement the counter.
  - When counter reaches 1, go to DONE on that edge and register product = accumulator[2*WIDTH-1:0].
- FSM DONE:
  - out_valid=1; product held stable.
  - On out_ready, go to IDLE; out_valid drops and in_ready rises on the next cycle.
  - No new accept in the same cycle as the output handshake.
- Latency: accept edge E; out_valid is high in the cycle after edge E+ITER. Example: WIDTH=32 gives 17 cycles.
- Throughput: one result per ITER+2 cycles at best.
- Arithmetic: the result equals the exact mathematical product truncated to 2*WIDTH bits, which is always exact for both modes. Signed -2^(W-1) * -2^(W-1) gives +2^(2W-2).
- Input side: in_valid while in_ready=0 is ignored; the source must hold it. Operand changes during BUSY have no effect.
- Output side: out_ready while out_valid=0 is ignored. If out_ready is held low in DONE, product and out_valid hold indefinitely.
- Reset mid-operation: immediate return to reset values; the partial result is discarded; no out_valid pulse.
- Input stability: X on a or b outside an accept cycle must not propagate into state.

Optional Feature:
- Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined: at accept, if a==0 or b==0, skip BUSY and go straight to DONE with product=0. out_valid is then high in the cycle after the accept edge (latency 1).
- Not defined: every operation takes ITER cycles regardless of operand values.

Test Plan:
1. WIDTH=32, is_signed=1, a=10, b=-5, out_ready=1 -> out_valid exactly 17 cycles after accept; product=64'hFFFFFFFFFFFFFFCE (-50); in_ready low throughout BUSY/DONE.
2. is_signed=0, a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001. Then the same operands with is_signed=1 -> product=1.
3. is_signed=1, a=b=32'h80000000 -> product=64'h4000000000000000. Then a=32'h80000000, b=1 -> 64'hFFFFFFFF80000000.
4. Back-pressure: a=15, b=20, out_ready=0 for 10 cycles after out_valid -> product=300 held stable, in_valid pulses ignored. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
5. Reset mid-op: assert rst_n=0 asynchronously 5 cycles into BUSY with a=-8, b=3 -> outputs immediately at reset values, no out_valid. After release, a=-8, b=3 -> -24.
6. Zero operand a=0, b=7 -> product=0. Latency is 1 cycle with SEQ_MUL_EARLY_TERM_EN and 17 cycles without. Also rerun a 200-vector random signed/unsigned compare against the `*` operator at WIDTH=8 and WIDTH=32.
